// File: rtl/gs_upscale_rgb_pkg.sv
// Shared types and constants for the greyscale-to-RGB 2x upscaler.
package gs_upscale_rgb_pkg;

  localparam int unsigned PIX_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } state_e;

endpackage

// File: rtl/gs_line_buf.sv
// Single-line pixel store: one write port, one registered read port, no reset on storage.
module gs_line_buf #(
  parameter int unsigned DEPTH  = 320,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/gs_upscale_rgb.sv
// Greyscale stream to RGB stream, each input pixel replicated into a 2x2 output block.
// Even output rows pass input through (and fill the line buffer); odd rows replay the buffer.
module gs_upscale_rgb
  import gs_upscale_rgb_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 320,
  parameter int unsigned IN_HEIGHT = 240
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_r,
  output logic [PIX_W-1:0] out_g,
  output logic [PIX_W-1:0] out_b,
  output logic             out_sof,
  output logic             out_eol,
  output logic             sync_err
);

  localparam int unsigned COL_W  = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int unsigned LINE_W = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IN_WIDTH - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(IN_HEIGHT - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [COL_W-1:0]  r_col;      // next column to write (EVEN) or read (ODD)
  logic [LINE_W-1:0] r_line;
  logic [COL_W-1:0]  r_out_col;  // column of the pixel currently offered
  logic [PIX_W-1:0]  r_pix;
  logic              r_valid;
  logic              r_copy;
  logic              r_first;
  logic              r_sync_err;
  logic              r_run;

  logic              w_out_fire;
  logic              w_copy1_fire;
  logic              w_held_last;
  logic              w_in_fire;
  logic              w_load;
  logic              w_rd_en;
  logic              w_resync;
  logic              w_wr_en;
  logic [COL_W-1:0]  w_wr_col;
  logic [PIX_W-1:0]  w_rd_data;
  logic [PIX_W-1:0]  w_pix;

  assign w_out_fire   = r_valid && out_ready;
  assign w_copy1_fire = w_out_fire && r_copy;
  assign w_held_last  = r_valid && (r_out_col == LAST_COL);

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_load      = 1'b0;
    w_rd_en     = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = r_run;
        if (in_valid && r_run && in_sof) begin
          w_load      = 1'b1;
          w_state_nxt = EVEN;
        end
      end
      EVEN: begin
        // Accept in the same cycle the held pixel's second copy leaves: no bubble.
        in_ready = (!r_valid || w_copy1_fire) && !w_held_last;
        if (in_valid && in_ready) begin
          w_load = 1'b1;
        end else if (w_copy1_fire && w_held_last) begin
          w_rd_en     = 1'b1;
          w_state_nxt = ODD;
        end
      end
      ODD: begin
        if (w_copy1_fire) begin
          if (w_held_last) begin
            w_state_nxt = (r_line == LAST_LINE) ? IDLE : EVEN;
          end else begin
            w_rd_en = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_in_fire = in_valid && in_ready;
  assign w_wr_col  = in_sof ? '0 : r_col;
  assign w_wr_en   = w_load;
  assign w_resync  = (r_state == EVEN) && w_in_fire && in_sof &&
                     ((r_col != '0) || (r_line != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col      <= '0;
      r_line     <= '0;
      r_out_col  <= '0;
      r_pix      <= '0;
      r_valid    <= 1'b0;
      r_copy     <= 1'b0;
      r_first    <= 1'b0;
      r_sync_err <= 1'b0;
      r_run      <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_sync_err <= w_resync;
      if (w_load) begin
        r_pix     <= in_data;
        r_valid   <= 1'b1;
        r_copy    <= 1'b0;
        r_first   <= in_sof;
        r_out_col <= w_wr_col;
        r_col     <= (w_wr_col == LAST_COL) ? '0 : w_wr_col + 1'b1;
        if (in_sof) begin
          r_line <= '0;
        end
      end else if (w_rd_en) begin
        r_valid   <= 1'b1;
        r_copy    <= 1'b0;
        r_first   <= 1'b0;
        r_out_col <= r_col;
        r_col     <= (r_col == LAST_COL) ? '0 : r_col + 1'b1;
      end else if (w_copy1_fire) begin
        r_valid <= 1'b0;
        r_copy  <= 1'b0;
        if (r_state == ODD) begin
          r_line <= (r_line == LAST_LINE) ? '0 : r_line + 1'b1;
        end
      end else if (w_out_fire) begin
        r_copy <= 1'b1;
      end
    end
  end

  gs_line_buf #(
    .DEPTH  (IN_WIDTH),
    .ADDR_W (COL_W),
    .DATA_W (PIX_W)
  ) u_line_buf (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_col),
    .i_wr_data (in_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_col),
    .o_rd_data (w_rd_data)
  );

  // Odd rows stream straight from the buffer's registered read port.
  assign w_pix     = (r_state == ODD) ? w_rd_data : r_pix;
  assign out_valid = r_valid;
  assign out_r     = w_pix;
  assign out_g     = w_pix;
  assign out_b     = w_pix;
  assign out_sof   = r_valid && r_first && !r_copy;
  assign out_eol   = r_valid && r_copy && (r_out_col == LAST_COL);
  assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_gs_upscale_rgb.sv
// Directed bench for gs_upscale_rgb at 4x2 input: frame replication, stalls, drop, resync, reset.
module tb_gs_upscale_rgb;

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic [11:0] r;
    logic [11:0] g;
    logic [11:0] b;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_data = '0;
  logic        in_sof = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_r;
  logic [11:0] out_g;
  logic [11:0] out_b;
  logic        out_sof;
  logic        out_eol;
  logic        sync_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_sync   = 0;
  bit   tgl      = 1'b0;
  bit   chk_odd  = 1'b0;
  bit   prv_stall = 1'b0;
  logic [38:0] prv_obs = '0;
  obs_t q[$];
  obs_t exp_q[$];
  logic [11:0] fr [8];

  gs_upscale_rgb #(
    .IN_WIDTH  (4),
    .IN_HEIGHT (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_g     (out_g),
    .out_b     (out_b),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = tgl ? ~out_ready : 1'b1;
    end
  end

  always @(negedge clk) begin
    obs_t o;
    if (rst_n) begin
      if (prv_stall) begin
        check("stall_hold", {out_valid, out_sof, out_eol, out_r, out_g, out_b}, prv_obs);
      end
      if (chk_odd && out_valid && (((q.size() / 8) % 2) == 1)) begin
        check("odd_in_ready", in_ready, 0);
      end
      if (sync_err) n_sync++;
      if (out_valid && out_ready) begin
        o.sof = out_sof;
        o.eol = out_eol;
        o.r   = out_r;
        o.g   = out_g;
        o.b   = out_b;
        q.push_back(o);
      end
      prv_stall = out_valid && !out_ready;
      prv_obs   = {1'b1, out_sof, out_eol, out_r, out_g, out_b};
    end else begin
      prv_stall = 1'b0;
    end
  end

  task automatic send_pix(input logic [11:0] d, input logic sof);
    int  n = 0;
    bit  done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        check("in_ready_timeout", 0, 1);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [11:0] p [8]);
    for (int i = 0; i < 8; i++) send_pix(p[i], (i == 0));
  endtask

  task automatic push_exp(input logic [11:0] v, input logic sof, input logic eol);
    obs_t e;
    e.sof = sof;
    e.eol = eol;
    e.r   = v;
    e.g   = v;
    e.b   = v;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input logic [11:0] p [8]);
    for (int ln = 0; ln < 2; ln++)
      for (int dup = 0; dup < 2; dup++)
        for (int c = 0; c < 4; c++)
          for (int cp = 0; cp < 2; cp++)
            push_exp(p[ln*4 + c], (ln == 0 && dup == 0 && c == 0 && cp == 0),
                     (c == 3 && cp == 1));
  endtask

  task automatic wait_out(input int n);
    int k = 0;
    while (q.size() < n && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_count"}, q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < q.size(); i++) begin
      check($sformatf("%s_px%0d", tag, i), q[i], exp_q[i]);
    end
    check({tag, "_idle_valid"}, out_valid, 0);
  endtask

  task automatic start_test();
    q.delete();
    exp_q.delete();
    n_sync = 0;
  endtask

  initial begin
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_sync_err", sync_err, 0);
    check("rst_out_sof", out_sof, 0);
    check("rst_out_eol", out_eol, 0);
    check("rst_out_rgb", {out_r, out_g, out_b}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Basic frame, sink always ready
    start_test();
    fr = '{12'd10, 12'd20, 12'd30, 12'd40, 12'd50, 12'd60, 12'd70, 12'd80};
    push_frame(fr);
    send_frame(fr);
    wait_out(32);
    compare_q("basic");
    check("basic_no_sync_err", n_sync, 0);

    // Same frame with sink toggling ready every cycle
    start_test();
    tgl     = 1'b1;
    chk_odd = 1'b1;
    push_frame(fr);
    send_frame(fr);
    wait_out(32);
    tgl     = 1'b0;
    chk_odd = 1'b0;
    @(posedge clk);
    #1;
    compare_q("stall");

    // Non-sof pixels in IDLE are dropped; then full-scale/zero grey values
    start_test();
    send_pix(12'd7, 1'b0);
    send_pix(12'd8, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("drop_count", q.size(), 0);
    check("drop_valid", out_valid, 0);
    fr = '{12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'hFFF, 12'h000, 12'hFFF};
    push_frame(fr);
    send_frame(fr);
    wait_out(32);
    compare_q("extreme");

    // Early sof on third pixel of row 0 restarts the frame
    start_test();
    push_exp(12'd1, 1'b1, 1'b0);
    push_exp(12'd1, 1'b0, 1'b0);
    push_exp(12'd2, 1'b0, 1'b0);
    push_exp(12'd2, 1'b0, 1'b0);
    fr = '{12'd3, 12'd4, 12'd5, 12'd6, 12'd11, 12'd12, 12'd13, 12'd14};
    push_frame(fr);
    send_pix(12'd1, 1'b1);
    send_pix(12'd2, 1'b0);
    send_frame(fr);
    wait_out(36);
    compare_q("resync");
    check("resync_pulses", n_sync, 1);

    // Reset in the middle of the first odd row
    start_test();
    fr = '{12'd10, 12'd20, 12'd30, 12'd40, 12'd50, 12'd60, 12'd70, 12'd80};
    for (int i = 0; i < 4; i++) send_pix(fr[i], (i == 0));
    begin
      int k = 0;
      while (q.size() < 10 && k < 200) begin
        @(posedge clk);
        #1;
        k++;
      end
    end
    check("mid_odd_reached", (q.size() >= 10), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_sof", out_sof, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start_test();
    check("post_rst_valid", out_valid, 0);
    fr = '{12'd21, 12'd22, 12'd23, 12'd24, 12'd25, 12'd26, 12'd27, 12'd28};
    push_frame(fr);
    send_pix(12'd99, 1'b0);
    send_frame(fr);
    wait_out(32);
    compare_q("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
